// File: rtl/sc_preamble_pkg.sv
// ============================================================================
// Module   : sc_preamble_pkg
// Brief    : Shared state encoding and defaults for the Schmidl-Cox preamble
//            transmit sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sc_preamble_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRIME = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_GUARD = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_PRIME = ST_PRIME,
    S_PLAY  = ST_PLAY,
    S_GUARD = ST_GUARD,
    S_DONE  = ST_DONE
  } state_t;

  localparam int         PREAMBLE_LEN_DEF = 128;
  localparam logic [9:0] IDLE_LEVEL_DEF   = 10'h200;

endpackage

`default_nettype wire

// File: rtl/preamble_tx_sequencer_sample_tick_gen.sv
// ============================================================================
// Module   : sample_tick_gen
// Brief    : SAMPLE_DIV down-counter; synchronous load forces a tick on the
//            next enabled cycle, then one tick every SAMPLE_DIV enabled cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_tick_gen #(
  parameter int SAMPLE_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_tick
);

  localparam int c_cnt_w = (SAMPLE_DIV < 2) ? 1 : $clog2(SAMPLE_DIV);
  localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(SAMPLE_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

  generate
    if (SAMPLE_DIV < 2) begin : g_div_check
      $error("sample_tick_gen: SAMPLE_DIV must be >= 2");
    end
  endgenerate

  logic [c_cnt_w-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? c_reload : (r_cnt - c_one);
    end
  end

endmodule

`default_nettype wire

// File: rtl/preamble_tx_sequencer.sv
// ============================================================================
// Module   : preamble_tx_sequencer
// Brief    : Plays the preamble ROM to the DAC sample register at the
//            programmed rate, then a mid-scale guard, then signals completion.
//            Optional macro PREAMBLE_REPEAT_EN adds i_repeat (passes-1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module preamble_tx_sequencer
  import sc_preamble_pkg::*;
#(
  parameter int                ADDR_W       = 8,
  parameter int                DATA_W       = 10,
  parameter int                PREAMBLE_LEN = PREAMBLE_LEN_DEF,
  parameter int                SAMPLE_DIV   = 4,
  parameter int                GUARD_LEN    = 16,
  parameter logic [DATA_W-1:0] IDLE_LEVEL   = DATA_W'(IDLE_LEVEL_DEF)
) (
  input  logic              clk,
  input  logic              reset,
`ifdef PREAMBLE_REPEAT_EN
  input  logic [3:0]        i_repeat,
`endif
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic [DATA_W-1:0] o_sample,
  output logic              o_sample_valid
);

  localparam int c_cnt_w  = $clog2(PREAMBLE_LEN) + 1;
  localparam int c_gcnt_w = $clog2(GUARD_LEN + 1) + 1;
  localparam logic [c_cnt_w-1:0]  c_last_smp   = c_cnt_w'(PREAMBLE_LEN - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_one    = c_cnt_w'(1);
  localparam logic [c_gcnt_w-1:0] c_last_guard = c_gcnt_w'((GUARD_LEN == 0) ? 0 : GUARD_LEN - 1);
  localparam logic [c_gcnt_w-1:0] c_gcnt_one   = c_gcnt_w'(1);
  localparam logic [ADDR_W-1:0]   c_addr_one   = ADDR_W'(1);

  generate
    if (PREAMBLE_LEN < 2 || PREAMBLE_LEN > (2 ** ADDR_W)) begin : g_len_check
      $error("preamble_tx_sequencer: PREAMBLE_LEN out of range");
    end
  endgenerate

  state_t              r_state;
  state_t              w_state_nx;
  logic [ADDR_W-1:0]   r_addr;
  logic [c_cnt_w-1:0]  r_smp_cnt;
  logic [c_gcnt_w-1:0] r_guard_cnt;
  logic [3:0]          r_pass_left;
  logic [3:0]          w_passes;
  logic [DATA_W-1:0]   r_sample;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;
  logic                w_tick;
  logic                w_play_tick;
  logic                w_guard_tick;
  logic                w_last_smp;

`ifdef PREAMBLE_REPEAT_EN
  assign w_passes = i_repeat;
`else
  assign w_passes = 4'd0;
`endif

  sample_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .i_load (r_state == S_PRIME),
    .i_en   ((r_state == S_PLAY) || (r_state == S_GUARD)),
    .o_tick (w_tick)
  );

  assign w_play_tick  = (r_state == S_PLAY)  && w_tick;
  assign w_guard_tick = (r_state == S_GUARD) && w_tick;
  assign w_last_smp   = (r_smp_cnt == c_last_smp);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nx = S_PRIME;
      S_PRIME: w_state_nx = S_PLAY;
      S_PLAY: begin
        if (w_play_tick && w_last_smp && (r_pass_left == 4'd0)) begin
          w_state_nx = (GUARD_LEN == 0) ? S_DONE : S_GUARD;
        end
      end
      S_GUARD: if (w_guard_tick && (r_guard_cnt == c_last_guard)) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    // Abort overrides everything, including a start arriving in IDLE.
    if (i_abort) w_state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_smp_cnt   <= '0;
      r_guard_cnt <= '0;
      r_pass_left <= '0;
      r_sample    <= IDLE_LEVEL;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx != S_IDLE);
      r_done  <= (w_state_nx == S_DONE);
      r_valid <= 1'b0;
      if (w_state_nx == S_IDLE) begin
        r_addr      <= '0;
        r_smp_cnt   <= '0;
        r_guard_cnt <= '0;
        r_sample    <= IDLE_LEVEL;
      end else begin
        if (r_state == S_IDLE) begin
          r_pass_left <= w_passes;
        end
        if (w_play_tick) begin
          r_sample <= i_rom_data;
          r_valid  <= 1'b1;
          // End of a pass: rewind so a following pass keeps the same cadence.
          if (w_last_smp) begin
            r_addr    <= '0;
            r_smp_cnt <= '0;
            if (r_pass_left != 4'd0) r_pass_left <= r_pass_left - 4'd1;
          end else begin
            r_addr    <= r_addr + c_addr_one;
            r_smp_cnt <= r_smp_cnt + c_cnt_one;
          end
        end else if (w_guard_tick) begin
          r_sample    <= IDLE_LEVEL;
          r_valid     <= 1'b1;
          r_guard_cnt <= r_guard_cnt + c_gcnt_one;
        end
      end
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_rom_addr     = r_addr;
  assign o_sample       = r_sample;
  assign o_sample_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_preamble_tx_sequencer.sv
// ============================================================================
// Module   : tb_preamble_tx_sequencer
// Brief    : Self-checking bench; unit 0 uses defaults (DIV 4, guard 16),
//            unit 1 uses SAMPLE_DIV=2, GUARD_LEN=0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_preamble_tx_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] start;
  logic [1:0] abort;
  logic [3:0] rep [2];
  logic [1:0] busy, done, valid;
  logic [7:0] addr [2];
  logic [9:0] rom_q [2];
  logic [9:0] smp [2];
  logic [9:0] rom [128];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  bit   m_act [2];
  int   m_c [2];
  int   m_p [2];
  logic [9:0] vq [2][$];
  int   vc [2][$];
  int   dcnt [2];
  int   dcyc [2];

  always #5 clk = ~clk;

  preamble_tx_sequencer dut0 (
    .clk(clk), .reset(reset),
`ifdef PREAMBLE_REPEAT_EN
    .i_repeat(rep[0]),
`endif
    .i_start(start[0]), .i_abort(abort[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_rom_addr(addr[0]), .i_rom_data(rom_q[0]), .o_sample(smp[0]), .o_sample_valid(valid[0])
  );

  preamble_tx_sequencer #(.SAMPLE_DIV(2), .GUARD_LEN(0)) dut1 (
    .clk(clk), .reset(reset),
`ifdef PREAMBLE_REPEAT_EN
    .i_repeat(rep[1]),
`endif
    .i_start(start[1]), .i_abort(abort[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_rom_addr(addr[1]), .i_rom_data(rom_q[1]), .o_sample(smp[1]), .o_sample_valid(valid[1])
  );

  // Registered ROM, one cycle of read latency.
  always @(posedge clk) begin
    rom_q[0] <= rom[addr[0][6:0]];
    rom_q[1] <= rom[addr[1][6:0]];
    cyc      <= cyc + 1;
  end

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int guard_of(input int i);
    return (i == 0) ? 16 : 0;
  endfunction

  // Cycle offset (start cycle = 0) of the DONE cycle for a run of p passes.
  function automatic int end_off(input int i, input int p);
    return 3 + div_of(i) * (128 * p + guard_of(i) - 1);
  endfunction

  function automatic int passes_of(input int i);
`ifdef PREAMBLE_REPEAT_EN
    return int'(rep[i]) + 1;
`else
    return 1 + 0 * i;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: tracks only "running, c cycles after the accepted start".
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_act[i] <= 1'b0;
      end else if (m_act[i]) begin
        if (abort[i] || m_c[i] == end_off(i, m_p[i])) m_act[i] <= 1'b0;
        else m_c[i] <= m_c[i] + 1;
      end else if (start[i] && !abort[i]) begin
        m_act[i] <= 1'b1;
        m_c[i]   <= 1;
        m_p[i]   <= passes_of(i);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin : cmp
        int c, d, k, tk, np, e;
        bit e_busy, e_done, e_valid;
        int e_smp, e_addr;
        c  = m_c[i];
        d  = div_of(i);
        np = 128 * m_p[i];
        e  = end_off(i, m_p[i]);
        e_busy  = m_act[i];
        e_done  = m_act[i] && (c == e);
        e_valid = m_act[i] && (c >= 3) && ((c - 3) % d == 0);
        k  = (c >= 3) ? (c - 3) / d : 0;
        tk = (m_act[i] && c >= 3) ? k + 1 : 0;
        e_smp  = (m_act[i] && c >= 3 && k < np) ? int'(rom[k % 128]) : 'h200;
        e_addr = (tk >= np) ? 0 : tk % 128;
        chk($sformatf("u%0d busy", i),   int'(busy[i]),  int'(e_busy));
        chk($sformatf("u%0d done", i),   int'(done[i]),  int'(e_done));
        chk($sformatf("u%0d valid", i),  int'(valid[i]), int'(e_valid));
        chk($sformatf("u%0d sample", i), int'(smp[i]),   e_smp);
        chk($sformatf("u%0d addr", i),   int'(addr[i]),  e_addr);
        if (valid[i]) begin
          vq[i].push_back(smp[i]);
          vc[i].push_back(cyc);
        end
        if (done[i]) begin
          dcnt[i] = dcnt[i] + 1;
          dcyc[i] = cyc;
        end
      end
    end
  end

  task automatic clr(input int i);
    vq[i].delete();
    vc[i].delete();
    dcnt[i] = 0;
    dcyc[i] = -1;
  endtask

  task automatic pulse_start(input int i, output int s);
    @(posedge clk); #1;
    start[i] = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (busy[i] && n < budget);
    if (busy[i]) chk($sformatf("u%0d run timeout busy", i), int'(busy[i]), 0);
  endtask

  task automatic wait_valids(input int i, input int cnt, input int budget);
    int n;
    n = 0;
    while (vq[i].size() < cnt && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk($sformatf("u%0d wait valids", i), vq[i].size() >= cnt, 1);
  endtask

  initial begin
    int s;
    for (int k = 0; k < 128; k++) rom[k] = 10'((k * 151 + 'h0A7) % 1024);
    rom[0] = 10'h200; rom[1] = 10'h1E2; rom[2] = 10'h2E3; rom[3] = 10'h1D9;
    start = '0; abort = '0; rep[0] = '0; rep[1] = '0; reset = 1'b0;
    clr(0); clr(1);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d reset busy", i),   int'(busy[i]),  0);
      chk($sformatf("u%0d reset done", i),   int'(done[i]),  0);
      chk($sformatf("u%0d reset valid", i),  int'(valid[i]), 0);
      chk($sformatf("u%0d reset sample", i), int'(smp[i]),   'h200);
      chk($sformatf("u%0d reset addr", i),   int'(addr[i]),  0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b1;

    // Plain run on unit 0
    clr(0);
    pulse_start(0, s);
    wait_done(0, 2000);
    chk("first valid latency", vc[0][0] - s, 3);
    chk("sample cadence", vc[0][1] - vc[0][0], 4);
    chk("sample0", int'(vq[0][0]), 'h200);
    chk("sample1", int'(vq[0][1]), 'h1E2);
    chk("sample2", int'(vq[0][2]), 'h2E3);
    chk("sample3", int'(vq[0][3]), 'h1D9);
    chk("guard sample", int'(vq[0][135]), 'h200);
    chk("valid count", vq[0].size(), 144);
    chk("done pulses", dcnt[0], 1);

    // Abort at the 50th sample, then a clean restart
    clr(0);
    pulse_start(0, s);
    wait_valids(0, 50, 1000);
    abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    @(negedge clk); #1;
    chk("abort busy", int'(busy[0]), 0);
    chk("abort valid", int'(valid[0]), 0);
    chk("abort sample", int'(smp[0]), 'h200);
    repeat (5) @(negedge clk);
    chk("abort no done", dcnt[0], 0);
    clr(0);
    pulse_start(0, s);
    wait_valids(0, 2, 100);
    chk("restart sample0", int'(vq[0][0]), 'h200);
    chk("restart sample1", int'(vq[0][1]), 'h1E2);
    wait_done(0, 2000);

    // Start held high: one run, then another only after returning to IDLE
    clr(0);
    @(posedge clk); #1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    wait_done(0, 2000);
    chk("held start first run", vq[0].size(), 144);
    chk("held start first done", dcnt[0], 1);
    repeat (10) @(negedge clk);
    #1 start[0] = 1'b0;
    wait_done(0, 2000);
    chk("held start total valids", vq[0].size(), 288);
    chk("held start total dones", dcnt[0], 2);

`ifdef PREAMBLE_REPEAT_EN
    // Three passes back to back
    clr(0);
    rep[0] = 4'd2;
    pulse_start(0, s);
    rep[0] = 4'd0;
    wait_done(0, 3000);
    chk("repeat valid count", vq[0].size(), 400);
    chk("repeat sample128", int'(vq[0][128]), 'h200);
    chk("repeat sample129", int'(vq[0][129]), 'h1E2);
    chk("repeat wrap gap", vc[0][128] - vc[0][127], 4);
    chk("repeat done pulses", dcnt[0], 1);
`endif

    // Unit 1: no guard, divide by 2
    clr(1);
    pulse_start(1, s);
    wait_done(1, 1000);
    chk("g0 first latency", vc[1][0] - s, 3);
    chk("g0 cadence", vc[1][1] - vc[1][0], 2);
    chk("g0 valid count", vq[1].size(), 128);
    chk("g0 done on last sample", dcyc[1], vc[1][127]);
    chk("g0 done pulses", dcnt[1], 1);

    // Abort and start together in IDLE
    clr(1);
    @(posedge clk); #1;
    start[1] = 1'b1;
    abort[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    abort[1] = 1'b0;
    @(negedge clk); #1;
    chk("abort+start busy", int'(busy[1]), 0);
    repeat (8) @(negedge clk);
    chk("abort+start valids", vq[1].size(), 0);
    chk("abort+start dones", dcnt[1], 0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
